// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, PC select
// codes and the saturating perf-counter helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_STALL    = 2'b01,
    ST_REDIRECT = 2'b10,
    ST_EXC      = 2'b11
  } state_e;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_JMP = 2'b10;
  localparam logic [1:0] PCSEL_EXC = 2'b11;

  localparam logic [15:0] PERF_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != PERF_MAX)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard/resolution detection: load-use against the EX load,
// and control-flow resolution of the instruction in MEM.
module hazard_detect (
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRt,
  input  logic [4:0] EX_Rw,
  input  logic       EX_RegWr,
  input  logic       EX_MemtoReg,
  input  logic       MEM_Branch,
  input  logic       MEM_Zero,
  input  logic       MEM_Jump,
  output logic       load_use,
  output logic       taken,
  output logic       is_jump
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = (EX_Rw == ID_Rs);
  assign w_rt_hit = ID_UsesRt && (EX_Rw == ID_Rt);

  // $0 is never a real destination, so a load into it cannot create a hazard
  assign load_use = EX_RegWr && EX_MemtoReg && (EX_Rw != 5'd0) && (w_rs_hit || w_rt_hit);
  assign taken    = (MEM_Branch && MEM_Zero) || MEM_Jump;
  assign is_jump  = MEM_Jump;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall / redirect / exception-drain FSM with
// registered control outputs. Optional perf counters under HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned EXC_HOLD = 2
) (
  input  logic       Clk,
  input  logic       Clrn,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRt,
  input  logic [4:0] EX_Rw,
  input  logic       EX_RegWr,
  input  logic       EX_MemtoReg,
  input  logic       MEM_Branch,
  input  logic       MEM_Zero,
  input  logic       MEM_Jump,
  input  logic       MEM_Overflow,
  output logic       PC_Wr,
  output logic       IFID_Wr,
  output logic       IFID_Flush,
  output logic       IDEX_Flush,
  output logic       EXMEM_Flush,
  output logic       MEMWB_Flush,
  output logic [1:0] PC_Sel,
  output logic [1:0] State
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] Stall_Cnt,
  output logic [15:0] Flush_Cnt
`endif
);

  localparam logic [3:0] CNT_LOAD = 4'(EXC_HOLD - 1);

  state_e     r_state;
  state_e     w_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  logic w_load_use;
  logic w_taken;
  logic w_is_jump;

  logic       r_pc_wr, r_ifid_wr;
  logic       r_ifid_fl, r_idex_fl, r_exmem_fl, r_memwb_fl;
  logic [1:0] r_pc_sel;

  logic       w_pc_wr, w_ifid_wr;
  logic       w_ifid_fl, w_idex_fl, w_exmem_fl, w_memwb_fl;
  logic [1:0] w_pc_sel;

  hazard_detect u_hazard_detect (
    .ID_Rs       (ID_Rs),
    .ID_Rt       (ID_Rt),
    .ID_UsesRt   (ID_UsesRt),
    .EX_Rw       (EX_Rw),
    .EX_RegWr    (EX_RegWr),
    .EX_MemtoReg (EX_MemtoReg),
    .MEM_Branch  (MEM_Branch),
    .MEM_Zero    (MEM_Zero),
    .MEM_Jump    (MEM_Jump),
    .load_use    (w_load_use),
    .taken       (w_taken),
    .is_jump     (w_is_jump)
  );

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      ST_RUN, ST_STALL: begin
        if (MEM_Overflow) begin
          w_next    = ST_EXC;
          w_cnt_nxt = CNT_LOAD;
        end else if (w_taken) begin
          w_next = ST_REDIRECT;
        end else if (w_load_use) begin
          w_next = ST_STALL;
        end else begin
          w_next = ST_RUN;
        end
      end
      // Everything sampled here belongs to instructions being flushed
      ST_REDIRECT: w_next = ST_RUN;
      ST_EXC: begin
        if (r_cnt == 4'd0) begin
          w_next = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with State
  always_comb begin
    w_pc_wr    = 1'b1;
    w_ifid_wr  = 1'b1;
    w_ifid_fl  = 1'b0;
    w_idex_fl  = 1'b0;
    w_exmem_fl = 1'b0;
    w_memwb_fl = 1'b0;
    w_pc_sel   = PCSEL_SEQ;
    unique case (w_next)
      ST_RUN: ;
      ST_STALL: begin
        w_pc_wr   = 1'b0;
        w_ifid_wr = 1'b0;
        w_idex_fl = 1'b1;
      end
      ST_REDIRECT: begin
        w_ifid_fl  = 1'b1;
        w_idex_fl  = 1'b1;
        w_exmem_fl = 1'b1;
        w_pc_sel   = w_is_jump ? PCSEL_JMP : PCSEL_BR;
      end
      ST_EXC: begin
        w_pc_wr    = (r_state != ST_EXC);
        w_ifid_wr  = 1'b0;
        w_ifid_fl  = 1'b1;
        w_idex_fl  = 1'b1;
        w_exmem_fl = 1'b1;
        w_memwb_fl = 1'b1;
        w_pc_sel   = (r_state != ST_EXC) ? PCSEL_EXC : PCSEL_SEQ;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_state    <= ST_RUN;
      r_cnt      <= '0;
      r_pc_wr    <= 1'b1;
      r_ifid_wr  <= 1'b1;
      r_ifid_fl  <= 1'b0;
      r_idex_fl  <= 1'b0;
      r_exmem_fl <= 1'b0;
      r_memwb_fl <= 1'b0;
      r_pc_sel   <= PCSEL_SEQ;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_nxt;
      r_pc_wr    <= w_pc_wr;
      r_ifid_wr  <= w_ifid_wr;
      r_ifid_fl  <= w_ifid_fl;
      r_idex_fl  <= w_idex_fl;
      r_exmem_fl <= w_exmem_fl;
      r_memwb_fl <= w_memwb_fl;
      r_pc_sel   <= w_pc_sel;
    end
  end

  assign State       = r_state;
  assign PC_Wr       = r_pc_wr;
  assign IFID_Wr     = r_ifid_wr;
  assign IFID_Flush  = r_ifid_fl;
  assign IDEX_Flush  = r_idex_fl;
  assign EXMEM_Flush = r_exmem_fl;
  assign MEMWB_Flush = r_memwb_fl;
  assign PC_Sel      = r_pc_sel;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic        w_flush_entry;

  assign w_flush_entry = (w_next == ST_REDIRECT) || ((w_next == ST_EXC) && (r_state != ST_EXC));

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= sat_inc(r_stall_cnt, r_state == ST_STALL);
      r_flush_cnt <= sat_inc(r_flush_cnt, w_flush_entry);
    end
  end

  assign Stall_Cnt = r_stall_cnt;
  assign Flush_Cnt = r_flush_cnt;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter EXC_HOLD, default 2, meaning number of cycles held in exception-drain state (legal 1..15).
REQ-002 SHALL have ports: Clk  in  1  clock; control state updates on posedge, decisions consumed by the negedge-clocked pipeline registers.
REQ-003 SHALL have ports: Clrn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID; ID_UsesRt  in  1  ID instruction reads Rt.
REQ-005 SHALL have ports: EX_Rw  in  5; EX_RegWr, EX_MemtoReg  in  1 each  destination and load indication of the instruction in EX.
REQ-006 SHALL have ports: MEM_Branch, MEM_Zero, MEM_Jump, MEM_Overflow  in  1 each  resolution flags of the instruction in MEM.
REQ-007 SHALL have ports: PC_Wr, IFID_Wr  out  1 each  write enables; IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush  out  1 each  bubble-insert requests.
REQ-008 SHALL have ports: PC_Sel  out  2  00 sequential, 01 branch target, 10 jump target, 11 exception vector; State  out  2  current state.

Function
REQ-009 SHALL implement states RUN=00, STALL=01, REDIRECT=10, EXC=11; all outputs registered, decoded from next state at posedge.
REQ-010 SHALL define load-use = EX_RegWr & EX_MemtoReg & (EX_Rw!=0) & ((EX_Rw==ID_Rs) | (ID_UsesRt & EX_Rw==ID_Rt)).
REQ-011 SHALL define taken = (MEM_Branch & MEM_Zero) | MEM_Jump; next-state priority MEM_Overflow > taken > load-use > RUN.
REQ-012 SHALL drive RUN outputs: PC_Wr=1, IFID_Wr=1, all flushes 0, PC_Sel=00.
REQ-013 SHALL drive STALL outputs: PC_Wr=0, IFID_Wr=0, IDEX_Flush=1, other flushes 0, PC_Sel=00; STALL lasts exactly one cycle unless a higher-priority event is sampled.
REQ-014 SHALL drive REDIRECT outputs: PC_Wr=1, IFID_Wr=1, IFID_Flush=IDEX_Flush=EXMEM_Flush=1, MEMWB_Flush=0; PC_Sel=10 if MEM_Jump else 01 (jump wins when both set); lasts one cycle.
REQ-015 SHALL drive EXC outputs: PC_Wr=1 on first EXC cycle only with PC_Sel=11, PC_Wr=0 and PC_Sel=00 thereafter; IFID_Wr=0; all four flushes 1.
REQ-016 SHALL hold EXC for exactly EXC_HOLD cycles using a 4-bit down-counter, ignoring all inputs, then return to RUN.
REQ-017 SHALL ignore load-use and taken while in REDIRECT (sampled instructions are being flushed); MEM_Overflow in REDIRECT also ignored.
REQ-018 SHALL, in STALL, leave STALL for REDIRECT or EXC if taken or MEM_Overflow is sampled; back-to-back load-use (new EX instruction) re-enters STALL.
REQ-019 SHALL never flag load-use for EX_Rw==0.

Reset
REQ-020 SHALL, while Clrn=0, asynchronously force State=RUN, counter=0, PC_Wr=1, IFID_Wr=1, all flushes 0, PC_Sel=00 (and perf counters 0).
REQ-021 SHALL, on reset during STALL/REDIRECT/EXC, abandon the operation immediately; first posedge after release evaluates from RUN.

Configuration
REQ-022 SHALL, with HAZARD_PERF_CNT_EN defined, add outputs Stall_Cnt and Flush_Cnt (16 bits each, saturating at 16'hFFFF), incremented per cycle spent in STALL and per entry into REDIRECT or EXC respectively.
REQ-023 SHALL, without HAZARD_PERF_CNT_EN, omit those ports and logic; all other behaviour identical.

Structure
REQ-024 SHALL place state encodings and PC_Sel codes in shared package pipe_ctrl_pkg.
REQ-025 SHALL implement hazard/resolution detection as combinational sub-module hazard_detect (outputs load_use, taken, is_jump); FSM, counter, output registers in pipe_hazard_ctrl.

Verification
REQ-026 SHALL cover: EX lw $8 (EX_Rw=8, RegWr=1, MemtoReg=1), ID_Rs=8 -> one STALL cycle, PC_Wr=0, IDEX_Flush=1, then RUN.
REQ-027 SHALL cover: same but EX_Rw=0 or ID_Rt=8 with ID_UsesRt=0 -> stays RUN.
REQ-028 SHALL cover: MEM_Branch=1, MEM_Zero=1 concurrent with load-use -> REDIRECT, PC_Sel=01, three flushes 1, no STALL.
REQ-029 SHALL cover: MEM_Overflow=1 with MEM_Jump=1, EXC_HOLD=3 -> EXC for 3 cycles, PC_Sel=11 first cycle only, then RUN.
REQ-030 SHALL cover: Clrn low mid-EXC -> State=00 and RUN outputs immediately without clock edge.
REQ-031 SHALL cover (HAZARD_PERF_CNT_EN): 70000 consecutive stalls -> Stall_Cnt=16'hFFFF holds.
